karat_mult_core: RTL and testbench
==================================

# karat_mult_core

Pipelined unsigned Karatsuba multiplier that computes the full 2·wI-bit product of two wI-bit operands. It uses nSTAGE levels of recursive halving, and each leaf is a direct multiplier. The block is the arithmetic core behind the MSM field-multiplication wrapper. That wrapper pads operands to a power of two and sets nSTAGE = log2(width) − 3, so leaves are 8 bits wide.

## Interface
- wI, 128: operand width; must be divisible by 2^nSTAGE.
- nSTAGE, 4: recursion depth; 0 means a single direct leaf multiplier.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- iX  input  wI  multiplicand, unsigned.
- iY  input  wI  multiplier, unsigned.
- i_enable  input  1  start strobe; iX/iY are sampled on a rising edge when high.
- oO  output  2·wI  product iX·iY.
- o_finish  output  1  one-cycle strobe marking oO valid.

## Operation
- Let h = wI/2. Split each operand into halves: X = X1·2^h + X0, Y = Y1·2^h + Y0.
- Subtractive Karatsuba, with all three sub-products h bits wide so recursion stays power-of-two:
  - z2 = X1·Y1
  - z0 = X0·Y0
  - dX = |X1−X0|, sX = (X1 < X0)
  - dY = |Y1−Y0|, sY = (Y1 < Y0)
  - zm = dX·dY
  - z1 = z2 + z0 − zm if sX⊕sY = 0; otherwise z1 = z2 + z0 + zm
  - oO = z2·2^wI + z1·2^h + z0
- Compute z1 in wI+2 bits; it is guaranteed non-negative. Truncate the final sum to 2·wI bits; it never overflows.
- Each of the three sub-products is a child instance with wI/2 and nSTAGE−1. At nSTAGE = 0, use the leaf multiplier.
- Carry the sign bit sX⊕sY in a delay line matching the child latency.
- Fully pipelined with throughput one operation per cycle. Every i_enable cycle launches an independent computation. There is no busy state and no backpressure.
- When i_enable is low, launch nothing. Pipeline data registers may toggle, but oO changes only on a cycle where o_finish is asserted.
- Held value: oO holds the last completed product until the next completion.

## Timing
- Leaf latency is 1 cycle: registered product.
- Level latency L(n) = L(n−1) + 1, because the combine step is registered. Total latency L = nSTAGE + 1 cycles from the i_enable sample edge to the o_finish/oO update edge (128/4 → 5 cycles).
- o_finish is i_enable delayed by exactly L cycles, through a valid shift register.
- Back-to-back enables give back-to-back o_finish pulses in launch order.
- Reset asserted (low), asynchronously:
  - oO = 0, o_finish = 0.
  - All valid bits cleared; in-flight operations are discarded and never produce o_finish.
- Reset released: i_enable is honoured on the first rising edge after release.
- i_enable high during reset is ignored.

## Configuration
- KARAT_MULT_OUT_REG_EN
  - Defined: adds one extra output register stage after the top-level combine. Latency becomes nSTAGE + 2, and o_finish is delayed to match. Applies at the top level only, not per recursion level.
  - Undefined: latency is nSTAGE + 1.

## Structure
- Package karat_mult_pkg holds:
  - function karat_latency(nSTAGE), which returns nSTAGE + 1, plus 1 under KARAT_MULT_OUT_REG_EN.
  - localparam for the leaf width convention: 8.
  - the width-check function (wI mod 2^nSTAGE == 0).
- Sub-module karat_mult_leaf: registered direct multiplier with valid passthrough, used at nSTAGE = 0.
- Recursion is a generate-guarded self-instantiation of karat_mult_core with three children.
- Elaboration-time assertion on the parameter constraint.

## Test plan
- wI=16, nSTAGE=1: 0xFFFF × 0xFFFF, enable one cycle → o_finish exactly 2 cycles later, oO = 0xFFFE0001.
- wI=16, nSTAGE=1: 0x00FF × 0xFF00 (sX=1, sY=0 path) → oO = 0x00FE0100; 0xFF00 × 0xFF00 (sX⊕sY=0) → oO = 0xFE010000.
- wI=128, nSTAGE=4: all-ones × all-ones → oO = 0xFFFF…FFFE followed by 0x0000…0001 (upper half 2^128−2, lower half 1), o_finish 5 cycles after enable; plus 1000 random operand pairs checked against a reference product.
- Back-to-back: enable 3 consecutive cycles with (3,5), (7,11), (0,0x1234) → o_finish high 3 consecutive cycles, oO = 15, 77, 0 in order.
- Reset mid-flight: enable, then pull reset low one cycle later → oO = 0 immediately, no o_finish after release; a new enable after release gives the correct product.
- KARAT_MULT_OUT_REG_EN defined: rerun the first scenario → o_finish 3 cycles after enable, same oO.

Source files
------------

// File: rtl/karat_mult_pkg.sv
// karat_mult_pkg: shared constants and helpers for the Karatsuba core.
// KARAT_MULT_OUT_REG_EN adds one top-level output register stage.
package karat_mult_pkg;

  localparam int KARAT_LEAF_W = 8;

`ifdef KARAT_MULT_OUT_REG_EN
  localparam int KARAT_OUT_EXTRA = 1;
`else
  localparam int KARAT_OUT_EXTRA = 0;
`endif

  function automatic int karat_latency(input int n_stage);
    return n_stage + 1 + KARAT_OUT_EXTRA;
  endfunction

  function automatic bit karat_width_ok(input int w, input int n_stage);
    return (w > 0) && ((w % (1 << n_stage)) == 0);
  endfunction

endpackage

// File: rtl/karat_mult_leaf.sv
// karat_mult_leaf: registered direct multiplier with valid passthrough.
// The product register only loads on enable, so it holds between results.
module karat_mult_leaf #(
  parameter int wI = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [wI-1:0]   iX,
  input  logic [wI-1:0]   iY,
  input  logic            i_enable,
  output logic [2*wI-1:0] oO,
  output logic            o_finish
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oO       <= '0;
      o_finish <= 1'b0;
    end else begin
      o_finish <= i_enable;
      if (i_enable)
        oO <= (2*wI)'(iX) * (2*wI)'(iY);
    end
  end

endmodule

// File: rtl/karat_mult_core.sv
// karat_mult_core: pipelined subtractive Karatsuba multiplier.
// KARAT_MULT_OUT_REG_EN adds an output register at the top level only.
module karat_mult_core
  import karat_mult_pkg::*;
#(
  parameter int wI     = 128,
  parameter int nSTAGE = 4,
  parameter bit TOP    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [wI-1:0]   iX,
  input  logic [wI-1:0]   iY,
  input  logic            i_enable,
  output logic [2*wI-1:0] oO,
  output logic            o_finish
);

  logic [2*wI-1:0] core_p;
  logic            core_v;

  if (!karat_width_ok(wI, nSTAGE)) begin : g_bad
    $error("karat_mult_core: wI must be divisible by 2**nSTAGE");
  end

  if (nSTAGE == 0) begin : g_leaf
    karat_mult_leaf #(.wI(wI)) u_leaf (
      .clk      (clk),
      .reset    (reset),
      .iX       (iX),
      .iY       (iY),
      .i_enable (i_enable),
      .oO       (core_p),
      .o_finish (core_v)
    );
  end else begin : g_rec
    localparam int H = wI / 2;

    logic [H-1:0]    x1, x0, y1, y0, dx, dy;
    logic            sx, sy;
    logic [wI-1:0]   z2, z0, zm;
    logic            f2, f0, fm, cv;
    logic [nSTAGE-1:0] sgn_d;
    logic [wI+1:0]   z1;
    logic [2*wI-1:0] sum;

    assign x1 = iX[wI-1:H];
    assign x0 = iX[H-1:0];
    assign y1 = iY[wI-1:H];
    assign y0 = iY[H-1:0];
    assign sx = x1 < x0;
    assign sy = y1 < y0;
    assign dx = sx ? x0 - x1 : x1 - x0;
    assign dy = sy ? y0 - y1 : y1 - y0;
    assign cv = f2 & f0 & fm;

    karat_mult_core #(.wI(H), .nSTAGE(nSTAGE-1), .TOP(1'b0)) u_z2 (
      .clk(clk), .reset(reset), .iX(x1), .iY(y1),
      .i_enable(i_enable), .oO(z2), .o_finish(f2)
    );

    karat_mult_core #(.wI(H), .nSTAGE(nSTAGE-1), .TOP(1'b0)) u_z0 (
      .clk(clk), .reset(reset), .iX(x0), .iY(y0),
      .i_enable(i_enable), .oO(z0), .o_finish(f0)
    );

    karat_mult_core #(.wI(H), .nSTAGE(nSTAGE-1), .TOP(1'b0)) u_zm (
      .clk(clk), .reset(reset), .iX(dx), .iY(dy),
      .i_enable(i_enable), .oO(zm), .o_finish(fm)
    );

    // sign of the middle term travels alongside the child pipelines
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sgn_d <= '0;
      end else begin
        sgn_d[0] <= sx ^ sy;
        for (int i = 1; i < nSTAGE; i++)
          sgn_d[i] <= sgn_d[i-1];
      end
    end

    always_comb begin
      z1 = '0;
      if (sgn_d[nSTAGE-1])
        z1 = (wI+2)'(z2) + (wI+2)'(z0) + (wI+2)'(zm);
      else
        z1 = (wI+2)'(z2) + (wI+2)'(z0) - (wI+2)'(zm);
      sum = {z2, z0} + ((2*wI)'(z1) << H);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        core_p <= '0;
        core_v <= 1'b0;
      end else begin
        core_v <= cv;
        if (cv)
          core_p <= sum;
      end
    end
  end

  if (TOP) begin : g_top_out
`ifdef KARAT_MULT_OUT_REG_EN
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        oO       <= '0;
        o_finish <= 1'b0;
      end else begin
        o_finish <= core_v;
        if (core_v)
          oO <= core_p;
      end
    end
`else
    assign oO       = core_p;
    assign o_finish = core_v;
`endif
  end else begin : g_inner_out
    assign oO       = core_p;
    assign o_finish = core_v;
  end

endmodule

// File: tb/tb_karat_mult_core.sv
// tb_karat_mult_core: randomized self-checking bench for karat_mult_core.
// Two instances (16/1 and 128/4) are checked against plain multiplication.
module tb_karat_mult_core;

`ifdef KARAT_MULT_OUT_REG_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif
  localparam int LS = 1 + 1 + XL;
  localparam int LB = 4 + 1 + XL;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  xs, ys;
  logic         ens;
  logic [31:0]  os;
  logic         fs;
  logic [127:0] xb, yb;
  logic         enb;
  logic [255:0] ob;
  logic         fb;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [255:0] big_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  karat_mult_core #(.wI(16), .nSTAGE(1)) u_small (
    .clk(clk), .reset(rst_n), .iX(xs), .iY(ys),
    .i_enable(ens), .oO(os), .o_finish(fs)
  );

  karat_mult_core #(.wI(128), .nSTAGE(4)) u_big (
    .clk(clk), .reset(rst_n), .iX(xb), .iY(yb),
    .i_enable(enb), .oO(ob), .o_finish(fb)
  );

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    case ($urandom_range(0, 9))
      0: r = '1;
      1: r = '0;
      2: r[127:64] = '0;
      3: r[63:0] = '1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic launch_small(input logic [15:0] x, input logic [15:0] y,
                              output int lat, output logic [31:0] val);
    @(negedge clk);
    xs = x; ys = y; ens = 1'b1;
    @(negedge clk);
    ens = 1'b0; xs = 16'($urandom); ys = 16'($urandom);
    lat = 0; val = 'x;
    for (int n = 1; n <= 12; n++) begin
      if (fs) begin
        lat = n; val = os;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic launch_big(input logic [127:0] x, input logic [127:0] y,
                            output int lat, output logic [255:0] val);
    @(negedge clk);
    xb = x; yb = y; enb = 1'b1;
    @(negedge clk);
    enb = 1'b0; xb = rand128(); yb = rand128();
    lat = 0; val = 'x;
    for (int n = 1; n <= 16; n++) begin
      if (fb) begin
        lat = n; val = ob;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int seen;
    rst_n = 1'b0;
    ens = 1'b1; xs = 16'hFFFF; ys = 16'hFFFF;
    enb = 1'b1; xb = '1; yb = '1;
    repeat (3) @(negedge clk);
    checks++;
    if (os !== 32'd0) begin
      errors++; $display("FAIL reset_os got %h exp 0", os);
    end
    checks++;
    if (fs !== 1'b0) begin
      errors++; $display("FAIL reset_fs got %b exp 0", fs);
    end
    checks++;
    if (ob !== 256'd0) begin
      errors++; $display("FAIL reset_ob got %h exp 0", ob);
    end
    checks++;
    if (fb !== 1'b0) begin
      errors++; $display("FAIL reset_fb got %b exp 0", fb);
    end
    ens = 1'b0; enb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (LB + 3) begin
      @(negedge clk);
      if (fs || fb) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_enable_ignored got %0d finishes exp 0", seen);
    end
    big_last = '0;
  endtask

  task automatic test_corner16;
    logic [15:0] vx [3];
    logic [15:0] vy [3];
    int lat;
    logic [31:0] val, exp;
    vx = '{16'hFFFF, 16'h00FF, 16'hFF00};
    vy = '{16'hFFFF, 16'hFF00, 16'hFF00};
    for (int i = 0; i < 3; i++) begin
      exp = 32'(vx[i]) * 32'(vy[i]);
      launch_small(vx[i], vy[i], lat, val);
      checks++;
      if (lat != LS) begin
        errors++; $display("FAIL corner%0d_latency got %0d exp %0d", i, lat, LS);
      end
      checks++;
      if (val !== exp) begin
        errors++; $display("FAIL corner%0d_value got %h exp %h", i, val, exp);
      end
      @(negedge clk);
      checks++;
      if (fs !== 1'b0 || os !== exp) begin
        errors++; $display("FAIL corner%0d_hold got %b/%h exp 0/%h", i, fs, os, exp);
      end
    end
  endtask

  task automatic test_ones128;
    int lat;
    logic [255:0] val, exp;
    exp = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'd1};
    launch_big('1, '1, lat, val);
    checks++;
    if (lat != LB) begin
      errors++; $display("FAIL ones128_latency got %0d exp %0d", lat, LB);
    end
    checks++;
    if (val !== exp) begin
      errors++; $display("FAIL ones128_value got %h exp %h", val, exp);
    end
    big_last = exp;
  endtask

  task automatic test_back_to_back;
    logic [15:0] bx [3];
    logic [15:0] by [3];
    logic        fa [16];
    logic [31:0] va [16];
    logic [31:0] exp;
    bx = '{16'd3, 16'd7, 16'd0};
    by = '{16'd5, 16'd11, 16'h1234};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fa[i] = fs; va[i] = os;
      ens = (i < 3);
      xs = (i < 3) ? bx[i] : 16'($urandom);
      ys = (i < 3) ? by[i] : 16'($urandom);
    end
    ens = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (fa[i] !== ((i >= LS) && (i < LS + 3))) begin
        errors++; $display("FAIL b2b_finish[%0d] got %b exp %b", i, fa[i], (i >= LS) && (i < LS + 3));
      end
    end
    for (int j = 0; j < 3; j++) begin
      exp = 32'(bx[j]) * 32'(by[j]);
      checks++;
      if (va[LS + j] !== exp) begin
        errors++; $display("FAIL b2b_value%0d got %0d exp %0d", j, va[LS + j], exp);
      end
    end
    checks++;
    if (va[15] !== 32'd0) begin
      errors++; $display("FAIL b2b_hold got %0d exp 0", va[15]);
    end
  endtask

  task automatic test_reset_midflight;
    int lat, seen;
    logic [127:0] a, b;
    logic [255:0] val, exp;
    @(negedge clk);
    xb = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    yb = 128'hFFFF_0000_AAAA_5555_0000_FFFF_5A5A_A5A5;
    enb = 1'b1;
    @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ob !== 256'd0 || fb !== 1'b0) begin
      errors++; $display("FAIL midflight_clear got %b/%h exp 0/0", fb, ob);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (LB + 3) begin
      @(negedge clk);
      if (fb) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midflight_ghost got %0d finishes exp 0", seen);
    end
    a = rand128(); b = rand128();
    exp = 256'(a) * 256'(b);
    launch_big(a, b, lat, val);
    checks++;
    if (lat != LB || val !== exp) begin
      errors++; $display("FAIL midflight_relaunch got %0d/%h exp %0d/%h", lat, val, LB, exp);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a = rand128(); b = rand128();
    exp = 256'(a) * 256'(b);
    xb = a; yb = b; enb = 1'b1;
    @(negedge clk);
    enb = 1'b0;
    lat = 0;
    for (int n = 1; n <= 16; n++) begin
      if (fb) begin
        lat = n; val = ob;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != LB || val !== exp) begin
      errors++; $display("FAIL first_edge_launch got %0d/%h exp %0d/%h", lat, val, LB, exp);
    end
    big_last = exp;
  endtask

  task automatic test_random;
    logic [255:0] q_val [$];
    int           q_cyc [$];
    logic [127:0] a, b;
    logic [255:0] exp;
    int launched = 0;
    int guard = 0;
    int lc;
    while ((launched < 1000 || q_val.size() > 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (fb) begin
        checks++;
        if (q_val.size() == 0) begin
          errors++; $display("FAIL rand_spurious got finish exp none at cycle %0d", cyc);
        end else begin
          exp = q_val.pop_front();
          lc = q_cyc.pop_front();
          if (ob !== exp) begin
            errors++; $display("FAIL rand_value got %h exp %h", ob, exp);
          end
          checks++;
          if (cyc - lc != LB - 1) begin
            errors++; $display("FAIL rand_latency got %0d exp %0d", cyc - lc + 1, LB);
          end
          big_last = exp;
        end
      end else begin
        checks++;
        if (ob !== big_last) begin
          errors++; $display("FAIL rand_hold got %h exp %h", ob, big_last);
        end
      end
      if (launched < 1000 && $urandom_range(0, 3) != 0) begin
        a = rand128(); b = rand128();
        xb = a; yb = b; enb = 1'b1;
        q_val.push_back(256'(a) * 256'(b));
        q_cyc.push_back(cyc + 1);
        launched++;
      end else begin
        enb = 1'b0; xb = rand128(); yb = rand128();
      end
    end
    enb = 1'b0;
    checks++;
    if (guard >= 5000) begin
      errors++; $display("FAIL rand_timeout got %0d pending exp 0", q_val.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ens = 1'b0; xs = '0; ys = '0;
    enb = 1'b0; xb = '0; yb = '0;
    big_last = '0;
    test_reset();
    test_corner16();
    test_ones128();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
